// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: FSM state encoding and the
// width of the dropped-packet counter (STREAM_DEMUX_DROP_EN builds only).
package stream_demux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } demux_state_e;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/stream_demux.sv
// One-in, NUM_CH-out packet demultiplexer with a single output register stage.
// Define STREAM_DEMUX_DROP_EN to discard out-of-range packets and count them.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        s_data,
    input  logic [SEL_W-1:0]         s_sel,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic [NUM_CH-1:0]        m_valid,
    output logic [NUM_CH-1:0]        m_last,
    input  logic [NUM_CH-1:0]        m_ready,
`ifdef STREAM_DEMUX_DROP_EN
    output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
    output logic                     busy
);

    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] CH_MAX   = SEL_W'(NUM_CH - 1);

    demux_state_e      r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_dest;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_out_valid;

    logic              w_oor;
    logic [SEL_W-1:0]  w_sel_fix;
    logic [SEL_W-1:0]  w_route;
    logic [NUM_CH-1:0] w_dest_oh;
    logic              w_dest_ready;
    logic              w_drop_beat;
    logic              w_in_fire;
    logic              w_load;
    logic              w_first;

    assign w_first   = (r_state == IDLE);
    assign w_oor     = ({1'b0, s_sel} >= CH_LIMIT);
    assign w_sel_fix = w_oor ? CH_MAX : s_sel;
    assign w_route   = w_first ? w_sel_fix : r_sel;

    always_comb begin
        w_dest_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_dest_oh[k] = (r_dest == SEL_W'(k));
        end
    end

    assign w_dest_ready = |(w_dest_oh & m_ready);

`ifdef STREAM_DEMUX_DROP_EN
    logic r_drop;

    // Dropped beats bypass the output register, so they never wait on m_ready.
    assign w_drop_beat = w_first ? w_oor : r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop   <= 1'b0;
            drop_cnt <= '0;
        end else if (w_in_fire && w_first) begin
            r_drop <= w_oor;
            if (w_oor && drop_cnt != DROP_CNT_MAX) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
`else
    assign w_drop_beat = 1'b0;
`endif

    assign s_ready   = !rst &&
                       (w_drop_beat || !r_out_valid || w_dest_ready);
    assign w_in_fire = s_valid && s_ready;
    assign w_load    = w_in_fire && !w_drop_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else if (w_in_fire) begin
            unique case (r_state)
                IDLE: begin
                    r_sel   <= w_sel_fix;
                    r_state <= s_last ? IDLE : PASS;
                end
                PASS: begin
                    if (s_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A load while draining replaces the register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_dest      <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_data      <= s_data;
            r_last      <= s_last;
            r_dest      <= w_route;
        end else if (r_out_valid && w_dest_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        m_valid = '0;
        m_last  = '0;
        m_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_out_valid && w_dest_oh[k]) begin
                m_valid[k]                 = 1'b1;
                m_last[k]                  = r_last;
                m_data[k*DATA_W +: DATA_W] = r_data;
            end
        end
    end

    assign busy = (r_state == PASS);

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: an 8-channel instance for routing,
// backpressure, reset and back-to-back cases, and a 6-channel one for range.
module tb_stream_demux;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic [2:0]  s_sel;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_valid;
    logic [7:0]  m_last;
    logic [7:0]  m_ready;
    logic        busy;

    logic [7:0]  t6_data;
    logic [2:0]  t6_sel;
    logic        t6_valid;
    logic        t6_last;
    logic        t6_ready;
    logic [47:0] t6_mdata;
    logic [5:0]  t6_mvalid;
    logic [5:0]  t6_mlast;
    logic [5:0]  t6_mready;
    logic        t6_busy;

`ifdef STREAM_DEMUX_DROP_EN
    logic [15:0] drop_cnt8;
    logic [15:0] drop_cnt6;
`endif

    exp_t q8[$];
    exp_t q6[$];
    int   pop_cyc[$];
    int   errors;
    int   checks;
    int   cyc;
    int   busy_cyc;

    stream_demux #(.DATA_W(8), .NUM_CH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
`ifdef STREAM_DEMUX_DROP_EN
        .drop_cnt(drop_cnt8),
`endif
        .busy    (busy)
    );

    stream_demux #(.DATA_W(8), .NUM_CH(6)) dut6 (
        .clk     (clk),
        .rst     (rst),
        .s_data  (t6_data),
        .s_sel   (t6_sel),
        .s_valid (t6_valid),
        .s_last  (t6_last),
        .s_ready (t6_ready),
        .m_data  (t6_mdata),
        .m_valid (t6_mvalid),
        .m_last  (t6_mlast),
        .m_ready (t6_mready),
`ifdef STREAM_DEMUX_DROP_EN
        .drop_cnt(drop_cnt6),
`endif
        .busy    (t6_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy) busy_cyc++;
        if (!rst) begin
            chk("onehot8", 64'($countones(m_valid) <= 1), 64'd1);
            if ((m_valid & m_ready) != 8'd0) begin
                if (q8.size() == 0) begin
                    chk("unexpected8", 64'(m_valid), 64'd0);
                end else begin
                    e = q8.pop_front();
                    pop_cyc.push_back(cyc);
                    chk("m_valid8", 64'(m_valid), 64'(8'd1 << e.ch));
                    chk("m_data8", m_data, 64'(e.data) << (e.ch * 8));
                    chk("m_last8", 64'(m_last), 64'({7'd0, e.last} << e.ch));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && t6_mvalid != 6'd0) begin
            if (q6.size() == 0) begin
                chk("unexpected6", 64'(t6_mvalid), 64'd0);
            end else begin
                e = q6.pop_front();
                chk("m_valid6", 64'(t6_mvalid), 64'(6'd1 << e.ch));
                chk("m_data6", 64'(t6_mdata), 64'(e.data) << (e.ch * 8));
                chk("m_last6", 64'(t6_mlast), 64'({5'd0, e.last} << e.ch));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic l,
                        input int ch, input bit push, output int stalls);
        exp_t e;
        s_sel   = 3'(sel);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        if (push) begin
            e.ch = ch; e.data = d; e.last = l;
            q8.push_back(e);
        end
        stalls = 0;
        @(negedge clk);
        while (!s_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        chk("send_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   st0, st1;
        exp_t e;
        errors = 0; checks = 0; cyc = 0; busy_cyc = 0;
        rst = 1'b1;
        s_data = '0; s_sel = '0; s_valid = 1'b0; s_last = 1'b0;
        m_ready = 8'hFF;
        t6_data = '0; t6_sel = '0; t6_valid = 1'b0; t6_last = 1'b0;
        t6_mready = 6'h3F;

        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single beat to channel 5.
        busy_cyc = 0;
        send(5, 8'hA5, 1'b1, 5, 1'b1, st0);
        idle(3);
        chk("single_busy", 64'(busy_cyc), 64'd0);

        // Four beats; sel changes after the first beat are ignored.
        busy_cyc = 0;
        send(2, 8'h11, 1'b0, 2, 1'b1, st0);
        send(6, 8'h22, 1'b0, 2, 1'b1, st0);
        send(6, 8'h33, 1'b0, 2, 1'b1, st0);
        send(6, 8'h44, 1'b1, 2, 1'b1, st0);
        idle(3);
        chk("pkt4_busy_cycles", 64'(busy_cyc), 64'd3);
        chk("pkt4_idle", 64'(busy), 64'd0);

        // Backpressure on channel 3 with a beat held.
        m_ready = 8'hF7;
        send(3, 8'hA1, 1'b0, 3, 1'b1, st0);
        s_sel = 3'd3; s_data = 8'hB2; s_last = 1'b0; s_valid = 1'b1;
        e.ch = 3; e.data = 8'hB2; e.last = 1'b0;
        q8.push_back(e);
        repeat (4) begin
            @(negedge clk);
            chk("hold_s_ready", 64'(s_ready), 64'd0);
            chk("hold_m_data", 64'(m_data[31:24]), 64'hA1);
            chk("hold_m_valid", 64'(m_valid), 64'h08);
        end
        @(posedge clk);
        #1 m_ready = 8'hFF;
        @(negedge clk);
        chk("release_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        send(3, 8'hC3, 1'b0, 3, 1'b1, st0);
        send(3, 8'hD4, 1'b1, 3, 1'b1, st1);
        chk("release_stall_c", 64'(st0), 64'd0);
        chk("release_stall_d", 64'(st1), 64'd0);
        idle(2);

        // Reset in the middle of a packet.
        send(4, 8'h55, 1'b0, 4, 1'b1, st0);
        idle(1);
        chk("mid_busy", 64'(busy), 64'd1);
        s_data = 8'h66; s_last = 1'b0; s_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_m_valid", 64'(m_valid), 64'd0);
        chk("post_rst_m_last", 64'(m_last), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        send(1, 8'h77, 1'b1, 1, 1'b1, st0);
        idle(2);

        // Back-to-back single-beat packets to different channels.
        send(0, 8'h80, 1'b1, 0, 1'b1, st0);
        send(4, 8'h84, 1'b1, 4, 1'b1, st1);
        idle(2);
        chk("b2b_stall", 64'(st0 + st1), 64'd0);
        if (pop_cyc.size() >= 2) begin
            chk("b2b_gap",
                64'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]),
                64'd1);
        end else begin
            chk("b2b_pops", 64'(pop_cyc.size()), 64'd2);
        end

        // Out-of-range select on the 6-channel instance.
        t6_sel = 3'd7; t6_data = 8'h9A; t6_last = 1'b0; t6_valid = 1'b1;
`ifndef STREAM_DEMUX_DROP_EN
        e.ch = 5; e.data = 8'h9A; e.last = 1'b0;
        q6.push_back(e);
`endif
        @(negedge clk);
        chk("oor_ready1", 64'(t6_ready), 64'd1);
        @(posedge clk);
        #1;
        t6_sel = 3'd0; t6_data = 8'h9B; t6_last = 1'b1;
`ifndef STREAM_DEMUX_DROP_EN
        e.ch = 5; e.data = 8'h9B; e.last = 1'b1;
        q6.push_back(e);
`endif
        @(negedge clk);
        chk("oor_ready2", 64'(t6_ready), 64'd1);
        @(posedge clk);
        #1 t6_valid = 1'b0;
        idle(3);
        chk("oor_busy", 64'(t6_busy), 64'd0);
`ifdef STREAM_DEMUX_DROP_EN
        chk("drop_cnt6", 64'(drop_cnt6), 64'd1);
        chk("drop_cnt8", 64'(drop_cnt8), 64'd0);
`endif

        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q6_drained", 64'(q6.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
